rt_fifo_arb: RTL and testbench

- Dual 8-bit FIFO (Tx "TF" and Rx "RF") sharing one 2*2^N x 8 RAM.
- Access is serialised by a one-hot arbiter FSM.
- Each FIFO presents its head word in a registered output (TDO/RDO), i.e. first-word-fall-through.
- Sits between a host/CPU interface and a serial engine, e.g. a UART/SPI core.

---
 rtl/rt_fifo_pkg.sv | 17 +
 rtl/rt_fifo_ram.sv | 24 ++
 rtl/rt_fifo_arb.sv | 199 +++++++++++++++++++
 tb/tb_rt_fifo_arb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rt_fifo_pkg.sv
// Shared types and constants for the dual Tx/Rx FIFO with a shared RAM.
// Holds the one-hot arbiter state encoding, FIFO select codes and data width.
package rt_fifo_pkg;

    localparam int DW = 8;

    localparam logic TF_SEL = 1'b0;
    localparam logic RF_SEL = 1'b1;

    typedef enum logic [3:0] {
        IDLE = 4'b1000,
        WR   = 4'b0100,
        RD   = 4'b0010,
        LD   = 4'b0001
    } state_t;

endpackage

// File: rtl/rt_fifo_ram.sv
// Shared storage for both FIFOs: 2^AW x DW, synchronous write, async read.
// Ports: Clk; we/wa/wd write port; ra address in, rd data out (combinational).
module rt_fifo_ram
    import rt_fifo_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge Clk) begin
        if (we) mem[wa] <= wd;
    end

    assign rd = mem[ra];

endmodule

// File: rtl/rt_fifo_arb.sv
// Dual 8-bit FIFO (Tx TF / Rx RF) sharing one RAM through a one-hot arbiter.
// Ports: Clk, Rst (sync, active high); per FIFO: x_Rst clear, x_Wr/x_Rd strobes,
// x_FF/x_EF flags, TDI/RDI write data, TDO/RDO registered head word.
// Optional RTFIFO_ERR_EN adds sticky TF_Err/RF_Err for illegal strobes.
module rt_fifo_arb
    import rt_fifo_pkg::*;
#(
    parameter int pRTFIFO_Bits = 2
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          TF_Rst,
    input  logic          TF_Wr,
    input  logic          TF_Rd,
    output logic          TF_FF,
    output logic          TF_EF,
    input  logic [DW-1:0] TDI,
    output logic [DW-1:0] TDO,
    input  logic          RF_Rst,
    input  logic          RF_Wr,
    input  logic          RF_Rd,
    output logic          RF_FF,
    output logic          RF_EF,
    input  logic [DW-1:0] RDI,
    output logic [DW-1:0] RDO
`ifdef RTFIFO_ERR_EN
    ,
    output logic          TF_Err,
    output logic          RF_Err
`endif
);

    localparam int N = pRTFIFO_Bits;
    localparam logic [N:0] FULL_X = {1'b1, {N{1'b0}}};

    state_t        CS, NS;
    logic          sel, sel_nxt;

    logic [N:0]    tf_wp, tf_rp, rf_wp, rf_rp;
    logic          tf_wr_req, tf_rd_req, rf_wr_req, rf_rd_req;
    logic [DW-1:0] tf_wd, rf_wd;

    logic          Rst_WR_TF, Rst_WR_RF, Rst_RD_TF, Rst_RD_RF;
    logic          WE_TDO, WE_RDO;

    logic          ram_we;
    logic [N:0]    ram_wa, ram_ra;
    logic [DW-1:0] ram_wd, ram_rd;
    logic          cur_ef, abort;

    assign TF_EF = (tf_wp == tf_rp);
    assign RF_EF = (rf_wp == rf_rp);
    assign TF_FF = ((tf_wp ^ tf_rp) == FULL_X);
    assign RF_FF = ((rf_wp ^ rf_rp) == FULL_X);

    // RAM address is {fifo_sel, pointer LSBs}
    assign ram_wa = (sel == RF_SEL) ? {RF_SEL, rf_wp[N-1:0]}
                                    : {TF_SEL, tf_wp[N-1:0]};
    assign ram_ra = (sel == RF_SEL) ? {RF_SEL, rf_rp[N-1:0]}
                                    : {TF_SEL, tf_rp[N-1:0]};
    assign ram_wd = (sel == RF_SEL) ? rf_wd : tf_wd;
    assign cur_ef = (sel == RF_SEL) ? RF_EF : TF_EF;

    // A per-FIFO clear kills any operation in flight on that FIFO
    assign abort = (CS != IDLE) &&
                   ((sel == RF_SEL) ? RF_Rst : TF_Rst);

    rt_fifo_ram #(.AW(N + 1)) u_ram (
        .Clk (Clk),
        .we  (ram_we),
        .wa  (ram_wa),
        .wd  (ram_wd),
        .ra  (ram_ra),
        .rd  (ram_rd)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            CS  <= IDLE;
            sel <= TF_SEL;
        end else begin
            CS  <= NS;
            sel <= sel_nxt;
        end
    end

    always_comb begin
        NS        = CS;
        sel_nxt   = sel;
        ram_we    = 1'b0;
        Rst_WR_TF = 1'b0;
        Rst_WR_RF = 1'b0;
        Rst_RD_TF = 1'b0;
        Rst_RD_RF = 1'b0;
        WE_TDO    = 1'b0;
        WE_RDO    = 1'b0;
        if (abort) begin
            NS = IDLE;
        end else begin
            case (CS)
                IDLE: begin
                    // Requests being cleared this edge must not start service
                    if (rf_rd_req && !RF_Rst) begin
                        NS = RD; sel_nxt = RF_SEL;
                    end else if (tf_wr_req && !TF_Rst) begin
                        NS = WR; sel_nxt = TF_SEL;
                    end else if (tf_rd_req && !TF_Rst) begin
                        NS = RD; sel_nxt = TF_SEL;
                    end else if (rf_wr_req && !RF_Rst) begin
                        NS = WR; sel_nxt = RF_SEL;
                    end
                end
                WR: begin
                    ram_we = 1'b1;
                    if (sel == RF_SEL) Rst_WR_RF = 1'b1;
                    else               Rst_WR_TF = 1'b1;
                    // First word into an empty FIFO must reach the head reg
                    NS = cur_ef ? LD : IDLE;
                end
                RD: begin
                    if (sel == RF_SEL) Rst_RD_RF = 1'b1;
                    else               Rst_RD_TF = 1'b1;
                    NS = LD;
                end
                LD: begin
                    if (sel == RF_SEL) WE_RDO = 1'b1;
                    else               WE_TDO = 1'b1;
                    NS = IDLE;
                end
                default: NS = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || TF_Rst) begin
            tf_wp     <= '0;
            tf_rp     <= '0;
            tf_wr_req <= 1'b0;
            tf_rd_req <= 1'b0;
            tf_wd     <= '0;
            TDO       <= '0;
        end else begin
            if (Rst_WR_TF) tf_wp <= tf_wp + 1'b1;
            if (Rst_RD_TF) tf_rp <= tf_rp + 1'b1;
            if (TF_Wr && !TF_FF) begin
                tf_wr_req <= 1'b1;
                tf_wd     <= TDI;
            end else if (Rst_WR_TF) begin
                tf_wr_req <= 1'b0;
            end
            if (TF_Rd && !TF_EF) tf_rd_req <= 1'b1;
            else if (Rst_RD_TF)  tf_rd_req <= 1'b0;
            if (WE_TDO) TDO <= ram_rd;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || RF_Rst) begin
            rf_wp     <= '0;
            rf_rp     <= '0;
            rf_wr_req <= 1'b0;
            rf_rd_req <= 1'b0;
            rf_wd     <= '0;
            RDO       <= '0;
        end else begin
            if (Rst_WR_RF) rf_wp <= rf_wp + 1'b1;
            if (Rst_RD_RF) rf_rp <= rf_rp + 1'b1;
            if (RF_Wr && !RF_FF) begin
                rf_wr_req <= 1'b1;
                rf_wd     <= RDI;
            end else if (Rst_WR_RF) begin
                rf_wr_req <= 1'b0;
            end
            if (RF_Rd && !RF_EF) rf_rd_req <= 1'b1;
            else if (Rst_RD_RF)  rf_rd_req <= 1'b0;
            if (WE_RDO) RDO <= ram_rd;
        end
    end

`ifdef RTFIFO_ERR_EN
    always_ff @(posedge Clk) begin
        if (Rst || TF_Rst)
            TF_Err <= 1'b0;
        else if ((TF_Wr && TF_FF) || (TF_Rd && TF_EF))
            TF_Err <= 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst || RF_Rst)
            RF_Err <= 1'b0;
        else if ((RF_Wr && RF_FF) || (RF_Rd && RF_EF))
            RF_Err <= 1'b1;
    end
`else
    // Illegal strobes are simply not latched by the request logic above
`endif

endmodule

// File: tb/tb_rt_fifo_arb.sv
// Self-checking bench for rt_fifo_arb: directed strobes, a small FIFO model
// and per-FIFO scoreboards of expected head-register loads.
module tb_rt_fifo_arb;
    import rt_fifo_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst, TF_Rst, TF_Wr, TF_Rd, RF_Rst, RF_Wr, RF_Rd;
    logic       TF_FF, TF_EF, RF_FF, RF_EF;
    logic [7:0] TDI, TDO, RDI, RDO;
`ifdef RTFIFO_ERR_EN
    logic       TF_Err, RF_Err;
`endif

    always #5 Clk = ~Clk;

    rt_fifo_arb #(.pRTFIFO_Bits(2)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .TF_Rst (TF_Rst),
        .TF_Wr  (TF_Wr),
        .TF_Rd  (TF_Rd),
        .TF_FF  (TF_FF),
        .TF_EF  (TF_EF),
        .TDI    (TDI),
        .TDO    (TDO),
        .RF_Rst (RF_Rst),
        .RF_Wr  (RF_Wr),
        .RF_Rd  (RF_Rd),
        .RF_FF  (RF_FF),
        .RF_EF  (RF_EF),
        .RDI    (RDI),
        .RDO    (RDO)
`ifdef RTFIFO_ERR_EN
        ,
        .TF_Err (TF_Err),
        .RF_Err (RF_Err)
`endif
    );

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] m_mem [2][4];
    int         m_wr [2];
    int         m_rd [2];
    logic [7:0] sb_t [$];
    logic [7:0] sb_r [$];
    logic       pend_t = 1'b0;
    logic       pend_r = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input int f, input logic [7:0] d);
        if (f == 0) sb_t.push_back(d);
        else        sb_r.push_back(d);
    endtask

    task automatic m_write(input int f, input logic [7:0] d);
        if (m_wr[f] - m_rd[f] < 4) begin
            if (m_wr[f] == m_rd[f]) sb_push(f, d);
            m_mem[f][m_wr[f] % 4] = d;
            m_wr[f]++;
        end
    endtask

    task automatic m_read(input int f);
        if (m_wr[f] != m_rd[f]) begin
            m_rd[f]++;
            sb_push(f, m_mem[f][m_rd[f] % 4]);
        end
    endtask

    // Every head-register load is matched against the oldest expectation
    always @(negedge Clk) begin
        if (pend_t) begin
            chk("tdo_sb_nonempty", 32'(sb_t.size() > 0), 1);
            if (sb_t.size() > 0) chk("tdo_load", TDO, sb_t.pop_front());
        end
        if (pend_r) begin
            chk("rdo_sb_nonempty", 32'(sb_r.size() > 0), 1);
            if (sb_r.size() > 0) chk("rdo_load", RDO, sb_r.pop_front());
        end
        pend_t = dut.WE_TDO;
        pend_r = dut.WE_RDO;
    end

    task automatic strobe(input bit tw, input logic [7:0] td,
                          input bit rw, input logic [7:0] rd,
                          input bit tr, input bit rr);
        @(negedge Clk);
        TF_Wr = tw; TDI = td; RF_Wr = rw; RDI = rd;
        TF_Rd = tr; RF_Rd = rr;
        if (tw) m_write(0, td);
        if (rw) m_write(1, rd);
        if (tr) m_read(0);
        if (rr) m_read(1);
        @(negedge Clk);
        TF_Wr = 0; RF_Wr = 0; TF_Rd = 0; RF_Rd = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_pulse(input int which, input string tag);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clk);
            seen = (which == 0) ? dut.Rst_WR_TF : dut.Rst_RD_RF;
        end
        chk(tag, 32'(seen), 1);
    endtask

    task automatic stay_idle(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk(tag, dut.CS, IDLE);
        end
    endtask

    initial begin
        Rst = 1; TF_Rst = 0; RF_Rst = 0;
        TF_Wr = 0; TF_Rd = 0; RF_Wr = 0; RF_Rd = 0;
        TDI = 0; RDI = 0;
        m_wr = '{0, 0};
        m_rd = '{0, 0};
        idle(3);
        Rst = 0;
        @(negedge Clk);
        chk("rst_cs", dut.CS, IDLE);
        chk("rst_tf_ef", TF_EF, 1);
        chk("rst_rf_ef", RF_EF, 1);
        chk("rst_tf_ff", TF_FF, 0);
        chk("rst_rf_ff", RF_FF, 0);
        chk("rst_tdo", TDO, 8'h00);
        chk("rst_rdo", RDO, 8'h00);

        strobe(1, 8'h55, 1, 8'hAA, 0, 0);
        wait_pulse(0, "rst_wr_tf_seen");
        chk("rf_ef_at_tf_wr", RF_EF, 1);
        idle(10);
        chk("wr1_tf_ef", TF_EF, 0);
        chk("wr1_rf_ef", RF_EF, 0);
        chk("wr1_tdo", TDO, 8'h55);
        chk("wr1_rdo", RDO, 8'hAA);

        for (int i = 0; i < 3; i++) begin
            strobe(1, 8'(i), 0, 8'h00, 0, 0);
            idle(6);
            strobe(0, 8'h00, 1, 8'(8'hFF - i), 0, 0);
            idle(6);
        end
        chk("fill_tf_ff", TF_FF, 1);
        chk("fill_rf_ff", RF_FF, 1);
        chk("fill_tdo", TDO, 8'h55);
        chk("fill_rdo", RDO, 8'hAA);

        strobe(1, 8'h99, 1, 8'h99, 0, 0);
        stay_idle("full_wr_cs");
        chk("full_tf_ff", TF_FF, 1);

        strobe(0, 8'h00, 0, 8'h00, 1, 1);
        wait_pulse(1, "rst_rd_rf_seen");
        chk("tf_ff_at_rf_rd", TF_FF, 1);
        idle(10);
        chk("rd1_tf_ff", TF_FF, 0);
        chk("rd1_rf_ff", RF_FF, 0);
        chk("rd1_tdo", TDO, 8'h00);
        chk("rd1_rdo", RDO, 8'hFF);

        for (int i = 0; i < 3; i++) begin
            strobe(0, 8'h00, 0, 8'h00, 1, 1);
            idle(8);
        end
        chk("drain_tf_ef", TF_EF, 1);
        chk("drain_rf_ef", RF_EF, 1);
        chk("drain_tdo_wrap", TDO, 8'h55);
        chk("drain_rdo_wrap", RDO, 8'hAA);

        strobe(0, 8'h00, 0, 8'h00, 1, 1);
        stay_idle("empty_rd_cs");

        strobe(1, 8'h77, 0, 8'h00, 0, 0);
        idle(8);
        chk("pre_clr_tf_ef", TF_EF, 0);
        @(negedge Clk);
        TF_Rst = 1;
        @(negedge Clk);
        TF_Rst = 0;
        m_wr[0] = 0;
        m_rd[0] = 0;
        chk("clr_tf_ef", TF_EF, 1);
        chk("clr_tdo", TDO, 8'h00);
        chk("clr_rdo_kept", RDO, 8'hAA);
        chk("clr_cs", dut.CS, IDLE);

        idle(2);
        chk("sb_t_drained", sb_t.size(), 0);
        chk("sb_r_drained", sb_r.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
